// File: rtl/ddr4_init_sequencer_pkg.sv
// Shared types and constants for the DDR4 power-up/initialization sequencer:
// FSM states, command-bus struct, mode-register opcodes and MRS issue order.
package ddr_package;

   typedef enum logic [3:0] {
      IDLE,
      RST_LOW,
      CKE_WAIT,
      XPR_WAIT,
      MRS,
      MRD_WAIT,
      MOD_WAIT,
      ZQCL,
      ZQ_WAIT,
      DONE
   } init_state_e;

   typedef struct packed {
      logic        cs_n;
      logic        act_n;
      logic        ras_n;
      logic        cas_n;
      logic        we_n;
      logic [1:0]  bg;
      logic [1:0]  ba;
      logic [13:0] addr;
   } ddr_cmd_t;

   localparam int MRS_COUNT = 7;

   // MR0 A1:A0 are replaced by the burst-length select latched at start.
   localparam logic [13:0] MR_INIT [0:6] = '{
      14'h0A50, 14'h0301, 14'h0028, 14'h0004, 14'h0800, 14'h0400, 14'h0817
   };

   localparam logic [2:0] MRS_ORDER [0:6] = '{
      3'd3, 3'd6, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0
   };

   localparam ddr_cmd_t CMD_DES = '{
      cs_n: 1'b1, act_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1,
      bg: 2'b00, ba: 2'b00, addr: 14'h0000
   };

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic ddr_cmd_t mrs_cmd(input logic [2:0] mr, input logic [13:0] opcode);
      ddr_cmd_t c;
      c       = CMD_DES;
      c.cs_n  = 1'b0;
      c.ras_n = 1'b0;
      c.cas_n = 1'b0;
      c.we_n  = 1'b0;
      c.bg    = {1'b0, mr[2]};
      c.ba    = mr[1:0];
      c.addr  = opcode;
      return c;
   endfunction

   // ZQ calibration: A10=1 selects the long (ZQCL) form, A10=0 the short (ZQCS).
   function automatic ddr_cmd_t zq_cmd(input logic long_cal);
      ddr_cmd_t c;
      c          = CMD_DES;
      c.cs_n     = 1'b0;
      c.we_n     = 1'b0;
      c.addr[10] = long_cal;
      return c;
   endfunction

endpackage

// File: rtl/ddr4_wait_timer.sv
// Loadable down-counter shared by every wait state of the init sequencer.
// Saturates at zero; expired is high while the count is zero.
module ddr4_wait_timer #(
   parameter int WIDTH = 10
) (
   input  logic             clock_t,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   output logic             expired
);

   logic [WIDTH-1:0] count_reg, count_next;

   always_comb begin
      count_next = count_reg;
      if (load)
         count_next = value;
      else if (count_reg != '0)
         count_next = count_reg - WIDTH'(1);
   end

   always_ff @(posedge clock_t or posedge reset) begin
      if (reset)
         count_reg <= '0;
      else
         count_reg <= count_next;
   end

   assign expired = (count_reg == '0);

endmodule

// File: rtl/ddr4_init_sequencer.sv
// DDR4 power-up sequencer: RESET_n, CKE, seven MRS writes and ZQCL, then config_done.
// Define PERIODIC_ZQCS_EN to add the zq_req/zq_gnt handshake and periodic ZQCS in DONE.
module ddr4_init_sequencer
   import ddr_package::*;
#(
   parameter int T_RESET_L = 16,
   parameter int T_CKE_L   = 20,
   parameter int T_XPR     = 24,
   parameter int T_MRD     = 8,
   parameter int T_MOD     = 24,
   parameter int T_ZQINIT  = 512
`ifdef PERIODIC_ZQCS_EN
   ,
   parameter int T_ZQCS_INT = 4096
`endif
) (
   input  logic        clock_t,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  bl_sel,
   output logic        reset_n,
   output logic        cke,
   output logic        cs_n,
   output logic        act_n,
   output logic        ras_n,
   output logic        cas_n,
   output logic        we_n,
   output logic [1:0]  bg,
   output logic [1:0]  ba,
   output logic [13:0] addr,
   output logic        mrs_rdy,
   output logic        zqcl_rdy,
   output logic        config_done,
   output logic        busy
`ifdef PERIODIC_ZQCS_EN
   ,
   output logic        zq_req,
   input  logic        zq_gnt
`endif
);

   localparam int MAX_INIT = max_of(max_of(max_of(T_RESET_L, T_CKE_L), max_of(T_XPR, T_MRD)),
                                    max_of(T_MOD, T_ZQINIT));
`ifdef PERIODIC_ZQCS_EN
   localparam int MAX_T = max_of(MAX_INIT, T_ZQCS_INT);
`else
   localparam int MAX_T = MAX_INIT;
`endif
   localparam int TIMER_W = $clog2(MAX_T) + 1;

   // The start cycle itself is the first cycle of the reset-low window, hence N-2.
   localparam logic [TIMER_W-1:0] LD_RESET_L = TIMER_W'(T_RESET_L - 2);
   localparam logic [TIMER_W-1:0] LD_CKE_L   = TIMER_W'(T_CKE_L - 1);
   localparam logic [TIMER_W-1:0] LD_XPR     = TIMER_W'(T_XPR - 1);
   localparam logic [TIMER_W-1:0] LD_MRD     = TIMER_W'(T_MRD - 1);
   localparam logic [TIMER_W-1:0] LD_MOD     = TIMER_W'(T_MOD - 1);
   localparam logic [TIMER_W-1:0] LD_ZQINIT  = TIMER_W'(T_ZQINIT - 1);
`ifdef PERIODIC_ZQCS_EN
   localparam logic [TIMER_W-1:0] LD_ZQCS_INT = TIMER_W'(T_ZQCS_INT - 1);
`endif
   localparam logic [2:0] LAST_MRS = 3'(MRS_COUNT - 1);

   init_state_e        state_reg, state_next;
   logic [2:0]         mrs_idx_reg, mrs_idx_next;
   logic [1:0]         bl_reg, bl_next;
   logic               tmr_load;
   logic [TIMER_W-1:0] tmr_value;
   logic               tmr_expired;
   logic [2:0]         mr_num;
   logic [13:0]        mr_opcode;
   ddr_cmd_t           cmd;
`ifdef PERIODIC_ZQCS_EN
   logic               zq_req_reg, zq_req_next;
   logic               zqcs_reg, zqcs_next;
`endif

   ddr4_wait_timer #(
      .WIDTH(TIMER_W)
   ) u_wait_timer (
      .clock_t (clock_t),
      .reset   (reset),
      .load    (tmr_load),
      .value   (tmr_value),
      .expired (tmr_expired)
   );

   always_ff @(posedge clock_t or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         mrs_idx_reg <= '0;
         bl_reg      <= '0;
`ifdef PERIODIC_ZQCS_EN
         zq_req_reg  <= 1'b0;
         zqcs_reg    <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         mrs_idx_reg <= mrs_idx_next;
         bl_reg      <= bl_next;
`ifdef PERIODIC_ZQCS_EN
         zq_req_reg  <= zq_req_next;
         zqcs_reg    <= zqcs_next;
`endif
      end
   end

   // Each timed segment loads the timer on entry so the count includes its origin cycle.
   always_comb begin
      state_next   = state_reg;
      mrs_idx_next = mrs_idx_reg;
      bl_next      = bl_reg;
      tmr_load     = 1'b0;
      tmr_value    = '0;
`ifdef PERIODIC_ZQCS_EN
      zq_req_next  = zq_req_reg;
      zqcs_next    = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = RST_LOW;
               bl_next    = bl_sel;
               tmr_load   = 1'b1;
               tmr_value  = LD_RESET_L;
            end
         end
         RST_LOW: begin
            if (tmr_expired) begin
               state_next = CKE_WAIT;
               tmr_load   = 1'b1;
               tmr_value  = LD_CKE_L;
            end
         end
         CKE_WAIT: begin
            if (tmr_expired) begin
               state_next = XPR_WAIT;
               tmr_load   = 1'b1;
               tmr_value  = LD_XPR;
            end
         end
         XPR_WAIT: begin
            if (tmr_expired) begin
               state_next = MRS;
               tmr_load   = 1'b1;
               tmr_value  = LD_MRD;
            end
         end
         MRS: begin
            if (mrs_idx_reg == LAST_MRS) begin
               state_next = MOD_WAIT;
            end else begin
               state_next   = MRD_WAIT;
               mrs_idx_next = mrs_idx_reg + 3'd1;
            end
         end
         MRD_WAIT: begin
            if (tmr_expired) begin
               state_next = MRS;
               tmr_load   = 1'b1;
               tmr_value  = (mrs_idx_reg == LAST_MRS) ? LD_MOD : LD_MRD;
            end
         end
         MOD_WAIT: begin
            if (tmr_expired) begin
               state_next = ZQCL;
               tmr_load   = 1'b1;
               tmr_value  = LD_ZQINIT;
            end
         end
         ZQCL: state_next = ZQ_WAIT;
         ZQ_WAIT: begin
            if (tmr_expired) begin
               state_next = DONE;
`ifdef PERIODIC_ZQCS_EN
               tmr_load   = 1'b1;
               tmr_value  = LD_ZQCS_INT;
`endif
            end
         end
         DONE: begin
`ifdef PERIODIC_ZQCS_EN
            if (zq_req_reg && zq_gnt) begin
               zq_req_next = 1'b0;
               zqcs_next   = 1'b1;
               tmr_load    = 1'b1;
               tmr_value   = LD_ZQCS_INT;
            end else if (tmr_expired) begin
               zq_req_next = 1'b1;
            end
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mr_num    = MRS_ORDER[mrs_idx_reg];
      mr_opcode = MR_INIT[mr_num];
      if (mr_num == 3'd0)
         mr_opcode[1:0] = bl_reg;
   end

   always_comb begin
      cmd         = CMD_DES;
      reset_n     = 1'b1;
      cke         = 1'b1;
      mrs_rdy     = 1'b0;
      zqcl_rdy    = 1'b0;
      config_done = 1'b0;
      busy        = 1'b1;
      case (state_reg)
         IDLE: begin
            reset_n = 1'b0;
            cke     = 1'b0;
            busy    = 1'b0;
         end
         RST_LOW: begin
            reset_n = 1'b0;
            cke     = 1'b0;
         end
         CKE_WAIT: cke = 1'b0;
         MRS: begin
            cmd     = mrs_cmd(mr_num, mr_opcode);
            mrs_rdy = 1'b1;
         end
         ZQCL: begin
            cmd      = zq_cmd(1'b1);
            zqcl_rdy = 1'b1;
         end
         DONE: begin
            config_done = 1'b1;
            busy        = 1'b0;
`ifdef PERIODIC_ZQCS_EN
            if (zqcs_reg)
               cmd = zq_cmd(1'b0);
`endif
         end
         default: ;
      endcase
   end

   assign cs_n  = cmd.cs_n;
   assign act_n = cmd.act_n;
   assign ras_n = cmd.ras_n;
   assign cas_n = cmd.cas_n;
   assign we_n  = cmd.we_n;
   assign bg    = cmd.bg;
   assign ba    = cmd.ba;
   assign addr  = cmd.addr;
`ifdef PERIODIC_ZQCS_EN
   assign zq_req = zq_req_reg;
`endif

endmodule

// File: tb/tb_ddr4_init_sequencer.sv
// Directed bench for ddr4_init_sequencer: table of init runs plus hand-written
// mid-sequence reset, start-poke and (with PERIODIC_ZQCS_EN) ZQCS handshake sequences.
module tb_ddr4_init_sequencer;

   typedef struct {
      logic [1:0]  bl_sel;
      logic        start_poke;
      logic [13:0] mr0_addr;
   } run_vec_t;

   typedef struct {
      logic [2:0]  mr;
      logic [13:0] addr;
   } mrs_vec_t;

   localparam logic [28:0] RESET_PINS = {7'b0011111, 4'b0000, 14'h0000, 4'b0000};
   localparam logic [28:0] DONE_PINS  = {7'b1111111, 4'b0000, 14'h0000, 4'b0010};

   logic        clock_t = 1'b0;
   logic        reset   = 1'b1;
   logic        start   = 1'b0;
   logic [1:0]  bl_sel  = 2'b00;
   logic        reset_n, cke, cs_n, act_n, ras_n, cas_n, we_n;
   logic [1:0]  bg, ba;
   logic [13:0] addr;
   logic        mrs_rdy, zqcl_rdy, config_done, busy;
`ifdef PERIODIC_ZQCS_EN
   logic        zq_req;
   logic        zq_gnt = 1'b0;
   int          t_req, t_zqcs, hold_err;
`endif

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          t_start, t_rn, t_cke, t_zq, t_done, n_mrs, n_zq;
   int          cke_drop, strobe_err, des_err, busy_err, seen;
   int          mrs_t [7];
   logic [3:0]  mrs_bgba [7];
   logic [13:0] mrs_addr [7];
   logic [13:0] zq_addr;
   run_vec_t    runs [3];
   mrs_vec_t    mrs_tab [7];

   always #5 clock_t = ~clock_t;

`ifdef PERIODIC_ZQCS_EN
   ddr4_init_sequencer #(.T_ZQCS_INT(64)) dut (
      .clock_t     (clock_t),
      .reset       (reset),
      .start       (start),
      .bl_sel      (bl_sel),
      .reset_n     (reset_n),
      .cke         (cke),
      .cs_n        (cs_n),
      .act_n       (act_n),
      .ras_n       (ras_n),
      .cas_n       (cas_n),
      .we_n        (we_n),
      .bg          (bg),
      .ba          (ba),
      .addr        (addr),
      .mrs_rdy     (mrs_rdy),
      .zqcl_rdy    (zqcl_rdy),
      .config_done (config_done),
      .busy        (busy),
      .zq_req      (zq_req),
      .zq_gnt      (zq_gnt)
   );
`else
   ddr4_init_sequencer dut (
      .clock_t     (clock_t),
      .reset       (reset),
      .start       (start),
      .bl_sel      (bl_sel),
      .reset_n     (reset_n),
      .cke         (cke),
      .cs_n        (cs_n),
      .act_n       (act_n),
      .ras_n       (ras_n),
      .cas_n       (cas_n),
      .we_n        (we_n),
      .bg          (bg),
      .ba          (ba),
      .addr        (addr),
      .mrs_rdy     (mrs_rdy),
      .zqcl_rdy    (zqcl_rdy),
      .config_done (config_done),
      .busy        (busy)
   );
`endif

   task automatic step();
      @(posedge clock_t);
      #1;
      cyc++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, $signed(act), act, $signed(exp), exp);
      end
   endtask

   function automatic logic [28:0] pins();
      return {reset_n, cke, cs_n, act_n, ras_n, cas_n, we_n, bg, ba, addr,
              mrs_rdy, zqcl_rdy, config_done, busy};
   endfunction

   task automatic do_reset(input string tag);
      reset = 1'b1;
      start = 1'b0;
      repeat (3) step();
      check({tag, "/reset_pins"}, 32'(pins()), 32'(RESET_PINS));
      reset = 1'b0;
      cyc   = 0;
   endtask

   task automatic sample_cycle();
      logic is_mrs, is_zq;
      is_mrs = !cs_n && act_n && !ras_n && !cas_n && !we_n;
      is_zq  = !cs_n && act_n && ras_n && cas_n && !we_n;
      if (reset_n && t_rn < 0) t_rn = cyc;
      if (cke && t_cke < 0) t_cke = cyc;
      if ((t_cke >= 0 && !cke) || (t_rn >= 0 && !reset_n)) cke_drop++;
      if (mrs_rdy !== is_mrs || zqcl_rdy !== is_zq) strobe_err++;
      if (cs_n && ({act_n, ras_n, cas_n, we_n} != 4'b1111 || bg != 2'b00 || ba != 2'b00 || addr != 14'h0))
         des_err++;
      if (is_mrs) begin
         if (n_mrs < 7) begin
            mrs_t[n_mrs]    = cyc;
            mrs_bgba[n_mrs] = {bg, ba};
            mrs_addr[n_mrs] = addr;
         end
         n_mrs++;
      end
      if (is_zq) begin
         t_zq    = cyc;
         zq_addr = addr;
         n_zq++;
      end
      if (config_done && t_done < 0) t_done = cyc;
      if (busy !== (t_done < 0)) busy_err++;
   endtask

   task automatic run_vec(input run_vec_t rv, input string tag);
      logic [13:0] exp_addr;
      t_rn = -1; t_cke = -1; t_zq = -1; t_done = -1; n_mrs = 0; n_zq = 0;
      cke_drop = 0; strobe_err = 0; des_err = 0; busy_err = 0; zq_addr = '0;
      for (int i = 0; i < 7; i++) begin
         mrs_t[i] = -1; mrs_bgba[i] = '0; mrs_addr[i] = '0;
      end
      repeat (5) step();
      t_start = cyc;
      bl_sel  = rv.bl_sel;
      start   = 1'b1;
      step();
      start  = 1'b0;
      bl_sel = ~rv.bl_sel;
      for (int k = 0; k < 900; k++) begin
         sample_cycle();
         if (t_done >= 0 && cyc >= t_done + 6) break;
         start = rv.start_poke && (cyc == t_start + 30 || cyc == t_start + 70 ||
                                   (t_done >= 0 && cyc == t_done + 2));
         step();
      end
      start = 1'b0;

      check({tag, "/reset_n_delay"}, t_rn - t_start, 16);
      check({tag, "/cke_delay"}, t_cke - t_rn, 20);
      check({tag, "/first_mrs_delay"}, mrs_t[0] - t_cke, 24);
      check({tag, "/mrs_count"}, n_mrs, 7);
      for (int i = 0; i < 7; i++) begin
         exp_addr = (mrs_tab[i].mr == 3'd0) ? rv.mr0_addr : mrs_tab[i].addr;
         check($sformatf("%s/mrs%0d_bg_ba", tag, i), 32'(mrs_bgba[i]), {29'd0, mrs_tab[i].mr});
         check($sformatf("%s/mrs%0d_addr", tag, i), 32'(mrs_addr[i]), 32'(exp_addr));
         if (i > 0)
            check($sformatf("%s/mrs%0d_spacing", tag, i), mrs_t[i] - mrs_t[i-1], 8);
      end
      check({tag, "/zqcl_count"}, n_zq, 1);
      check({tag, "/zqcl_delay"}, t_zq - mrs_t[6], 24);
      check({tag, "/zqcl_addr"}, 32'(zq_addr), 32'h0400);
      check({tag, "/done_delay"}, t_done - t_zq, 512);
      check({tag, "/pin_drops"}, cke_drop, 0);
      check({tag, "/strobe_errors"}, strobe_err, 0);
      check({tag, "/des_errors"}, des_err, 0);
      check({tag, "/busy_errors"}, busy_err, 0);
      check({tag, "/done_pins"}, 32'(pins()), 32'(DONE_PINS));
   endtask

   initial begin
      runs[0] = '{bl_sel: 2'b01, start_poke: 1'b1, mr0_addr: 14'h0A51};
      runs[1] = '{bl_sel: 2'b10, start_poke: 1'b0, mr0_addr: 14'h0A52};
      runs[2] = '{bl_sel: 2'b11, start_poke: 1'b1, mr0_addr: 14'h0A53};

      mrs_tab[0] = '{mr: 3'd3, addr: 14'h0004};
      mrs_tab[1] = '{mr: 3'd6, addr: 14'h0817};
      mrs_tab[2] = '{mr: 3'd5, addr: 14'h0400};
      mrs_tab[3] = '{mr: 3'd4, addr: 14'h0800};
      mrs_tab[4] = '{mr: 3'd2, addr: 14'h0028};
      mrs_tab[5] = '{mr: 3'd1, addr: 14'h0301};
      mrs_tab[6] = '{mr: 3'd0, addr: 14'h0A50};

      for (int r = 0; r < 3; r++) begin
         do_reset($sformatf("run%0d", r));
         run_vec(runs[r], $sformatf("run%0d", r));
      end

      // Reset inside the third MRD_WAIT must clear every output before the next edge.
      do_reset("midrst");
      repeat (5) step();
      bl_sel = 2'b11;
      start  = 1'b1;
      step();
      start = 1'b0;
      seen  = 0;
      for (int k = 0; k < 300 && seen < 3; k++) begin
         step();
         if (!cs_n && act_n && !ras_n && !cas_n && !we_n) seen++;
      end
      check("midrst/third_mrs_seen", seen, 3);
      step();
      step();
      check("midrst/cke_before", 32'(cke), 32'd1);
      #3 reset = 1'b1;
      #1;
      check("midrst/pins_async", 32'(pins()), 32'(RESET_PINS));
      step();
      check("midrst/pins_held", 32'(pins()), 32'(RESET_PINS));
      reset = 1'b0;
      cyc   = 0;
      run_vec(runs[1], "replay");

`ifdef PERIODIC_ZQCS_EN
      t_req = -1;
      for (int k = 0; k < 200 && t_req < 0; k++) begin
         if (zq_req) t_req = cyc;
         else step();
      end
      check("zqcs/req_delay", t_req - t_done, 64);
      hold_err = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (!zq_req || !cs_n || !config_done) hold_err++;
      end
      check("zqcs/req_hold", hold_err, 0);
      zq_gnt = 1'b1;
      step();
      zq_gnt = 1'b0;
      t_zqcs = cyc;
      check("zqcs/cmd_pins", {27'd0, cs_n, act_n, ras_n, cas_n, we_n}, 32'b01110);
      check("zqcs/addr", 32'(addr), 32'h0000);
      check("zqcs/req_dropped", 32'(zq_req), 32'd0);
      check("zqcs/done_held", 32'(config_done), 32'd1);
      check("zqcs/zqcl_rdy_low", 32'(zqcl_rdy), 32'd0);
      step();
      check("zqcs/one_cycle", 32'(cs_n), 32'd1);
      t_req = -1;
      for (int k = 0; k < 200 && t_req < 0; k++) begin
         if (zq_req) t_req = cyc;
         else step();
      end
      check("zqcs/reload_delay", t_req - t_zqcs, 64);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
